accum_seq: RTL and testbench
============================

// Module: accum_seq
// PURPOSE
//  Sequential multi-operand accumulator; consumer/driver of the parameterized ripple adder.
//  Accepts a burst of LEN W-bit operands over a valid/ready handshake.
//  Sums the burst with one W-bit adder_carry_para; its cout increments a CNT_W-bit high word.
//  Presents the (W+CNT_W)-bit total with a one-cycle done tick.
//  Used by datapaths that need n-word sums without a wide combinational adder tree.
// PARAMETERS
//  W      8  operand width; also the width of the instantiated adder
//  CNT_W  4  burst-length width; max burst = 2**CNT_W-1; high-word width
// PORTS
//  clk        in   1        system clock, rising edge
//  reset      in   1        asynchronous, active-high reset
//  start      in   1        begin a burst; sampled only in IDLE
//  len        in   CNT_W    operand count, sampled with start
//  din_valid  in   1        operand valid
//  din        in   W        operand
//  din_ready  out  1        operand accepted when din_valid & din_ready
//  busy       out  1        high in ACC and DONE
//  done_tick  out  1        one-cycle pulse, result valid from this cycle
//  result     out  W+CNT_W  registered sum {hi,lo}; held until next done
//  abort      in   1        only with ACCUM_ABORT_EN
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is asynchronous, active-high.
//  Reset: state=IDLE; acc_lo, acc_hi, cnt and result = 0; din_ready, busy, done_tick = 0.
//  FSM is accum_state_t: IDLE, ACC, DONE.
//  IDLE:
//   - start & len!=0: acc_lo=0, acc_hi=0, cnt=len -> ACC.
//   - start & len==0: acc=0 -> DONE; result becomes 0.
//  ACC:
//   - din_ready=1 (Moore, registered state decode).
//   - On accept: acc_lo<=sum(acc_lo,din); acc_hi<=acc_hi+cout; cnt<=cnt-1.
//   - Accept with cnt==1: result<={acc_hi+cout, sum} -> DONE.
//   - No accept: hold all state. din_valid without ready is never consumed.
//  DONE: done_tick=1, busy=1, din_ready=0 for exactly one cycle -> IDLE.
//  start while busy: ignored, no queuing.
//   - start is accepted again on the cycle after DONE, i.e. back-to-back bursts have 1 idle cycle.
//  Latency: done_tick one cycle after the last accept; LEN-operand burst takes >= LEN+2 cycles from start.
//  Width: the sum cannot overflow. hi increments <= LEN-1 <= 2**CNT_W-2.
//  result changes only on the DONE transition.
//  Reset mid-burst: returns to IDLE immediately; result is cleared to 0.
// CONFIGURATION
//  `define ACCUM_ABORT_EN: adds input port abort.
//   - abort in ACC: -> IDLE next cycle; no done_tick; result unchanged.
//   - Any operand accepted in the same cycle is discarded.
//   - abort has priority over completion.
//   - abort is ignored in IDLE and DONE.
//  Undefined: port absent; every burst runs to completion.
// STRUCTURE
//  accum_pkg: typedef enum logic [1:0] accum_state_t {IDLE, ACC, DONE};
//   localparam encodings only, no width parameters.
//  Sub-module: one adder_carry_para #(.N(W)):
//   - a=acc_lo, b=din, sum -> next lo, cout -> hi increment.
//  Rest: state/next-state always_ff/always_comb pair, cnt down-counter, result register.
// TESTING (W=8, CNT_W=4)
//  1. Reset asserted mid-ACC, asynchronously between edges
//     -> outputs 0 immediately, state IDLE, result=0.
//  2. start, len=3; din FF,FF,02 with valid every cycle
//     -> result=12'h200; done_tick 1 cycle after the 3rd accept; busy low next cycle.
//  3. len=15, all din=FF -> result=12'hEF1 (3825).
//  4. start, len=0 -> done_tick next cycle, result=0, din_ready never asserted.
//  5. len=4, din_valid toggled 1-0-0-1-1-0-1; start pulsed while busy
//     -> only the 4 valid beats summed; extra start ignored; one done_tick.
//  6. (ACCUM_ABORT_EN) prior result=12'h123; start len=5; abort after 2 accepts
//     -> no done_tick, result stays 12'h123, IDLE; new burst sums correctly from 0.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types for the sequential accumulator.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } accum_state_t;

endpackage

// File: rtl/adder_carry_para.sv
// Parameterised N-bit ripple-carry adder (carry-in tied low).
module adder_carry_para #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    // Bit-serial carry chain from LSB to MSB.
    always_comb begin
        sum   = '0;
        carry = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[N];
    end

endmodule

// File: rtl/accum_seq.sv
// Sequential multi-operand accumulator: sums a burst of len operands with a
// single W-bit ripple adder; adder carries increment a CNT_W-bit high word.
// Optional feature: define ACCUM_ABORT_EN to add the abort input.
module accum_seq
    import accum_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   len,
    input  logic               din_valid,
    input  logic [W-1:0]       din,
    output logic               din_ready,
    output logic               busy,
    output logic               done_tick,
    output logic [W+CNT_W-1:0] result
`ifdef ACCUM_ABORT_EN
    ,
    input  logic               abort
`endif
);

    accum_state_t     state;
    logic [W-1:0]     acc_lo;
    logic [CNT_W-1:0] acc_hi;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     sum;
    logic             cout;
    logic [CNT_W-1:0] hi_next;
    logic             abort_hit;

    adder_carry_para #(.N(W)) u_adder (
        .a    (acc_lo),
        .b    (din),
        .sum  (sum),
        .cout (cout)
    );

    // High word advances by the carry out of the low-word add.
    always_comb begin
        hi_next = acc_hi + CNT_W'(cout);
    end

`ifdef ACCUM_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Burst control, accumulation and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc_lo    <= '0;
            acc_hi    <= '0;
            cnt       <= '0;
            result    <= '0;
            din_ready <= 1'b0;
            busy      <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_lo <= '0;
                        acc_hi <= '0;
                        busy   <= 1'b1;
                        if (len != '0) begin
                            cnt       <= len;
                            din_ready <= 1'b1;
                            state     <= ACC;
                        end else begin
                            result    <= '0;
                            done_tick <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ACC: begin
                    // abort wins over an accept or completion in the same cycle
                    if (abort_hit) begin
                        din_ready <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (din_valid) begin
                        acc_lo <= sum;
                        acc_hi <= hi_next;
                        cnt    <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            result    <= {hi_next, sum};
                            din_ready <= 1'b0;
                            done_tick <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    din_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_seq.sv
// Self-checking bench for accum_seq (W=8, CNT_W=4) with a burst-level model.
`timescale 1ns/1ps
module tb_accum_seq;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic [3:0]  len       = '0;
    logic        din_valid = 1'b0;
    logic [7:0]  din       = '0;
    logic        din_ready;
    logic        busy;
    logic        done_tick;
    logic [11:0] result;
`ifdef ACCUM_ABORT_EN
    logic        abort     = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    // Model: operands still owed, running arithmetic total, tick pending.
    int          m_rem    = 0;
    int          m_total  = 0;
    bit          m_tick   = 1'b0;
    logic [11:0] m_result = '0;

    int done_count = 0;
    bit end_tick, end_busy, end_ready;
    int ops[$];

    accum_seq #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .busy      (busy),
        .done_tick (done_tick),
        .result    (result)
`ifdef ACCUM_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem    = 0;
        m_total  = 0;
        m_tick   = 1'b0;
        m_result = '0;
    endtask

    task automatic model_step();
        bit ab = 1'b0;
`ifdef ACCUM_ABORT_EN
        ab = abort;
`endif
        if (m_tick) begin
            m_tick = 1'b0;
        end else if (m_rem > 0) begin
            if (ab) begin
                m_rem = 0;
            end else if (din_valid) begin
                m_total += din;
                m_rem--;
                if (m_rem == 0) begin
                    m_result = m_total[11:0];
                    m_tick   = 1'b1;
                end
            end
        end else if (start) begin
            m_total = 0;
            if (len == 0) begin
                m_result = '0;
                m_tick   = 1'b1;
            end else begin
                m_rem = len;
            end
        end
    endtask

    // Advance the model on each edge, then compare all outputs shortly after.
    always @(posedge clk) begin
        if (!reset) model_step();
        #1;
        if (!reset) begin
            check("din_ready", din_ready, (m_rem > 0));
            check("busy", busy, (m_rem > 0) || m_tick);
            check("done_tick", done_tick, m_tick);
            check("result", result, m_result);
            if (done_tick) done_count++;
        end
    end

    // Caller is at a negedge with the DUT idle; returns at a negedge in IDLE.
    task automatic burst(input int l, input bit rnd, output int cyc);
        int k = 0;
        cyc = 0;
        start = 1'b1;
        len = l[3:0];
        din_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (k < l && cyc < 200) begin
            din_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            din = (k < ops.size()) ? 8'(ops[k]) : 8'($urandom_range(0, 255));
            if (din_valid && din_ready) k++;
            @(negedge clk);
            cyc++;
        end
        din_valid = 1'b0;
        check("burst_accepts", k, l);
        end_tick  = done_tick;
        end_ready = din_ready;
        // a start during the done cycle must be ignored
        start = 1'($urandom_range(0, 1));
        len   = 4'($urandom_range(0, 15));
        @(negedge clk);
        start = 1'b0;
        end_busy = busy;
        ops.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, d0, k, exp_sum, l;
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

        model_reset();
        #2;
        check("rst_din_ready", din_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done_tick", done_tick, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // FF + FF + 02, valid every cycle
        ops = '{255, 255, 2};
        burst(3, 1'b0, cyc);
        check("t2_result", result, 12'h200);
        check("t2_accept_cycles", cyc, 3);
        check("t2_tick_after_last", end_tick, 1);
        check("t2_busy_low_after", end_busy, 0);

        // asynchronous reset in the middle of a burst
        start = 1'b1; len = 4'd5;
        @(negedge clk);
        start = 1'b0; din_valid = 1'b1; din = 8'h10;
        @(negedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("t1_din_ready", din_ready, 0);
        check("t1_busy", busy, 0);
        check("t1_done_tick", done_tick, 0);
        check("t1_result", result, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // longest burst, all ones
        for (int i = 0; i < 15; i++) ops.push_back(255);
        burst(15, 1'b0, cyc);
        check("t3_result", result, 12'hEF1);

        // zero-length burst
        burst(0, 1'b0, cyc);
        check("t4_result", result, 0);
        check("t4_tick", end_tick, 1);
        check("t4_no_ready", end_ready, 0);
        check("t4_no_accept_cycles", cyc, 0);

        // sparse valid, extra start while busy
        ops = '{11, 22, 33, 44};
        d0 = done_count;
        start = 1'b1; len = 4'd4;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            din_valid = pat[i][0];
            din = pat[i][0] ? 8'(ops[k]) : 8'hEE;
            start = (i == 2);
            if (pat[i] != 0) k++;
            @(negedge clk);
        end
        din_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_result", result, 12'h06E);
        check("t5_one_done", done_count - d0, 1);
        ops.delete();

`ifdef ACCUM_ABORT_EN
        ops = '{255, 36};
        burst(2, 1'b0, cyc);
        check("t6_pre_result", result, 12'h123);
        d0 = done_count;
        start = 1'b1; len = 4'd5;
        @(negedge clk);
        start = 1'b0; din_valid = 1'b1; din = 8'h40;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        check("t6_no_done", done_count - d0, 0);
        check("t6_result_kept", result, 12'h123);
        check("t6_idle", busy, 0);
        ops = '{1, 2, 3};
        burst(3, 1'b0, cyc);
        check("t6_fresh_sum", result, 12'h006);
`endif

        // randomized bursts, back to back
        for (int b = 0; b < 25; b++) begin
            l = $urandom_range(0, 15);
            exp_sum = 0;
            for (int i = 0; i < l; i++) begin
                ops.push_back($urandom_range(0, 255));
                exp_sum += ops[i];
            end
            burst(l, 1'b1, cyc);
            check("rand_result", result, exp_sum);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
